// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared definitions for the program loader: program depth, instruction
// width, FSM state encoding and the word-count decode helper.
package program_loader_pkg;

  localparam int PROG_DEPTH = 256;
  localparam int INSTR_W    = 32;

  typedef enum logic [2:0] {
    PL_IDLE  = 3'd0,
    PL_COUNT = 3'd1,
    PL_DATA  = 3'd2,
    PL_CHECK = 3'd3,
    PL_RUN   = 3'd4
  } pl_state_e;

  // A count byte of 0 stands for 256 words; the result is clipped to the
  // RAM depth so the loader never addresses past the end of the RAM.
  function automatic logic [8:0] clip_count(input logic [7:0] b, input int depth);
    logic [8:0] n;
    n = (b == 8'd0) ? 9'd256 : {1'b0, b};
    if (int'(n) > depth) n = 9'(depth);
    return n;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if
// Byte-stream handshake plus the CPU instruction fetch port.
//   byte_in / byte_valid / byte_ready : stream into the loader
//   instruction_pointer / instruction : combinational CPU fetch
// master: stream source and CPU side. slave: the loader.
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  import program_loader_pkg::*;

  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic [ADDR_W-1:0]  instruction_pointer;
  logic [INSTR_W-1:0] instruction;

  modport master (
    output byte_in, byte_valid, instruction_pointer,
    input  byte_ready, instruction
  );

  modport slave (
    input  byte_in, byte_valid, instruction_pointer,
    output byte_ready, instruction
  );
endinterface

// File: rtl/program_loader_ram.sv
// program_ram
// DEPTH x 32 program store. One synchronous write port, one asynchronous
// read port, no reset (validity is tracked by the loader's count).
//   clk   : write clock
//   we    : write enable, waddr/wdata written on rising edge
//   raddr : read address, rdata follows combinationally
module program_ram
  import program_loader_pkg::*;
#(
  parameter int DEPTH  = PROG_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// program_loader
// Receives a program as a byte stream (count, 4*N big-endian data bytes,
// XOR checksum), packs it into 32-bit words in program_ram and serves the
// CPU fetch port. cpu_run stays low until a load has verified.
//   clk, resetn : clock, async active-low reset
//   load_start  : pulse, begins or restarts a load session
//   bus         : byte stream handshake + instruction fetch (slave)
//   cpu_run     : verified program resident
//   load_done   : one-cycle pulse on checksum match
//   load_error  : sticky checksum mismatch, cleared by load_start
//   word_count  : words loaded (0 = none, 8'hFF also used for 256)
//
// state    | meaning
// ---------+-------------------------------------------------
// PL_IDLE  | no session; stream not accepted
// PL_COUNT | waiting for the word-count byte
// PL_DATA  | packing data bytes into words, writing RAM
// PL_CHECK | waiting for the checksum byte
// PL_RUN   | verified program resident, CPU released
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH  = PROG_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_start,
  program_loader_if.slave  bus,
  output logic             cpu_run,
  output logic             load_done,
  output logic             load_error,
  output logic [7:0]       word_count
);

  pl_state_e          state_q, state_d;
  logic [8:0]         n_q, n_d;
  logic [ADDR_W-1:0]  word_idx_q, word_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [23:0]        asm_q, asm_d;
  logic [7:0]         acc_q, acc_d;
  logic [7:0]         wc_q, wc_d;
  logic               full_q, full_d;
  logic               err_q, err_d;
  logic               done_d;
  logic               byte_ready_q;
  logic               run_q;
  logic               done_q;
  logic               accept;
  logic               ram_we;
  logic [INSTR_W-1:0] ram_wdata;
  logic [INSTR_W-1:0] ram_rdata;
  logic [ADDR_W-1:0]  last_idx;
  logic [8:0]         ptr9;

  // A byte coinciding with load_start belongs to no session and is dropped.
  assign accept   = bus.byte_valid && byte_ready_q && !load_start;
  assign last_idx = ADDR_W'(n_q - 9'd1);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    acc_d      = acc_q;
    wc_d       = wc_q;
    full_d     = full_q;
    err_d      = err_q;
    done_d     = 1'b0;
    ram_we     = 1'b0;
    ram_wdata  = {asm_q, bus.byte_in};

    if (load_start) begin
      state_d = PL_COUNT;
      err_d   = 1'b0;
      wc_d    = 8'd0;
      full_d  = 1'b0;
    end else begin
      case (state_q)
        PL_COUNT: begin
          if (accept) begin
            n_d        = clip_count(bus.byte_in, DEPTH);
            word_idx_d = '0;
            byte_idx_d = 2'd0;
            acc_d      = 8'd0;
            state_d    = PL_DATA;
          end
        end
        PL_DATA: begin
          if (accept) begin
            // Only the first three bytes of a word need storing; the fourth
            // is merged straight into the RAM write data.
            asm_d      = {asm_q[15:0], bus.byte_in};
            acc_d      = acc_q ^ bus.byte_in;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              ram_we = 1'b1;
              if (word_idx_q == last_idx) state_d = PL_CHECK;
              else                        word_idx_d = word_idx_q + ADDR_W'(1);
            end
          end
        end
        PL_CHECK: begin
          if (accept) begin
            if (bus.byte_in == acc_q) begin
              state_d = PL_RUN;
              done_d  = 1'b1;
              wc_d    = n_q[7:0];
              full_d  = n_q[8];
            end else begin
              state_d = PL_IDLE;
              err_d   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= PL_IDLE;
      n_q          <= 9'd0;
      word_idx_q   <= '0;
      byte_idx_q   <= 2'd0;
      asm_q        <= 24'd0;
      acc_q        <= 8'd0;
      wc_q         <= 8'd0;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
      byte_ready_q <= 1'b0;
      run_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      acc_q        <= acc_d;
      wc_q         <= wc_d;
      full_q       <= full_d;
      err_q        <= err_d;
      byte_ready_q <= (state_d == PL_COUNT) || (state_d == PL_DATA) || (state_d == PL_CHECK);
      run_q        <= (state_d == PL_RUN);
      done_q       <= done_d;
    end
  end

  program_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (word_idx_q),
    .wdata (ram_wdata),
    .raddr (bus.instruction_pointer),
    .rdata (ram_rdata)
  );

  // {full, wc} is the true 9-bit word count; RAM contents beyond it (or
  // left over from an earlier or failed load) are never presented.
  assign ptr9            = 9'(bus.instruction_pointer);
  assign bus.instruction = (ptr9 < {full_q, wc_q}) ? ram_rdata : '0;
  assign bus.byte_ready  = byte_ready_q;
  assign cpu_run         = run_q;
  assign load_done       = done_q;
  assign load_error      = err_q;
  assign word_count      = full_q ? 8'hFF : wc_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  import program_loader_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       load_start = 1'b0;
  logic       cpu_run, load_done, load_error;
  logic [7:0] word_count;

  program_loader_if #(.ADDR_W(8)) pif ();

  program_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load_start (load_start),
    .bus        (pif.slave),
    .cpu_run    (cpu_run),
    .load_done  (load_done),
    .load_error (load_error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ok;
    int cnt;
  } exp_t;

  int          n_checks = 0;
  int          n_pass = 0;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  int          ref_cnt = 0;
  int          xfers = 0;
  logic [7:0]  stream[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk)
    if (resetn && !load_start && pif.byte_valid && pif.byte_ready) xfers++;

  // Monitor: every outcome the DUT reports must match the next scoreboard entry.
  logic err_prev = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (load_done) begin
      if (exp_q.size() == 0) chk("unexpected_load_done", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("outcome_is_success", 32'd1, 32'(mon_e.ok));
        chk("done_word_count", 32'(word_count),
            (mon_e.cnt == 256) ? 32'hFF : 32'(mon_e.cnt));
        chk("done_cpu_run", 32'(cpu_run), 32'd1);
      end
    end
    if (load_error && !err_prev) begin
      if (exp_q.size() == 0) chk("unexpected_load_error", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("outcome_is_error", 32'd0, 32'(mon_e.ok));
        chk("error_word_count", 32'(word_count), 32'd0);
        chk("error_cpu_run", 32'(cpu_run), 32'd0);
      end
    end
    err_prev = load_error;
  end

  task automatic add_word(input logic [31:0] w);
    stream.push_back(w[31:24]);
    stream.push_back(w[23:16]);
    stream.push_back(w[15:8]);
    stream.push_back(w[7:0]);
  endtask

  task automatic finish_stream(input logic [7:0] corrupt);
    logic [7:0] x;
    x = 8'd0;
    for (int i = 1; i < stream.size(); i++) x ^= stream[i];
    stream.push_back(x ^ corrupt);
  endtask

  task automatic pulse_start(input bit junk);
    @(negedge clk);
    load_start     = 1'b1;
    pif.byte_valid = junk;
    pif.byte_in    = 8'hA5;
    @(negedge clk);
    load_start     = 1'b0;
    pif.byte_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    @(negedge clk);
    if (gaps) begin
      pif.byte_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    pif.byte_in    = b;
    pif.byte_valid = 1'b1;
    t = 0;
    while (!pif.byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!pif.byte_ready) begin
      chk("byte_ready_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk);
  endtask

  // Reference model: decode the whole session from the stream rules and
  // queue the expected outcome before the bytes go out.
  task automatic run_load(input bit gaps, input bit junk);
    int n, xf0, t;
    logic [7:0] x;
    pulse_start(junk);
    ref_cnt = 0;
    xf0 = xfers;
    n = (stream[0] == 8'd0) ? 256 : int'(stream[0]);
    if (stream.size() == 4 * n + 2) begin
      x = 8'd0;
      for (int i = 1; i <= 4 * n; i++) x ^= stream[i];
      if (stream[4 * n + 1] == x) begin
        for (int i = 0; i < n; i++)
          ref_mem[i] = {stream[1+4*i], stream[2+4*i], stream[3+4*i], stream[4+4*i]};
        ref_cnt = n;
        exp_q.push_back('{1'b1, n});
      end else begin
        exp_q.push_back('{1'b0, 0});
      end
    end
    foreach (stream[i]) send_byte(stream[i], gaps);
    @(negedge clk);
    pif.byte_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("outcome_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    chk("transfer_count", 32'(xfers - xf0), 32'(stream.size()));
  endtask

  task automatic check_read(input int p);
    logic [31:0] e;
    @(negedge clk);
    pif.instruction_pointer = 8'(p);
    #1;
    e = (p < ref_cnt) ? ref_mem[p] : 32'h0;
    chk($sformatf("read[%0d]", p), pif.instruction, e);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    pif.instruction_pointer = 8'd0;
    #1;
    chk({tag, "_byte_ready"}, 32'(pif.byte_ready), 32'd0);
    chk({tag, "_cpu_run"},    32'(cpu_run),        32'd0);
    chk({tag, "_load_done"},  32'(load_done),      32'd0);
    chk({tag, "_load_error"}, 32'(load_error),     32'd0);
    chk({tag, "_word_count"}, 32'(word_count),     32'd0);
    chk({tag, "_instr"},      pif.instruction,     32'h0);
  endtask

  initial begin
    int n, xf0;
    pif.byte_in = 8'd0;
    pif.byte_valid = 1'b0;
    pif.instruction_pointer = 8'd0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check_reset_outputs("reset");

    // Two words; XOR of all eight data bytes is 8'h44.
    stream = {8'd2};
    add_word(32'h11223344);
    add_word(32'hA0B0C0D0);
    stream.push_back(8'h44);
    run_load(1'b0, 1'b0);
    check_read(1);
    check_read(2);
    check_read(0);

    stream[9] = 8'h45;
    run_load(1'b0, 1'b0);
    check_read(0);
    chk("bad_cksum_load_error", 32'(load_error), 32'd1);
    chk("bad_cksum_cpu_run", 32'(cpu_run), 32'd0);

    // Abort mid-data, then restart with a junk byte alongside load_start.
    stream = {8'd3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load(1'b0, 1'b0);
    stream = {8'd1, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    run_load(1'b0, 1'b1);
    check_read(0);
    check_read(1);

    run_load(1'b1, 1'b0);
    check_read(0);

    stream = {8'd0};
    for (int i = 0; i < 256; i++) add_word(32'(i));
    stream.push_back(8'h00);
    run_load(1'b0, 1'b0);
    check_read(255);
    check_read(254);
    check_read(0);
    chk("full_word_count", 32'(word_count), 32'hFF);
    chk("full_cpu_run", 32'(cpu_run), 32'd1);

    for (int s = 0; s < 20; s++) begin
      n = $urandom_range(1, 12);
      stream = {8'(n)};
      for (int w = 0; w < n; w++) add_word($urandom);
      finish_stream(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0);
      run_load(1'($urandom_range(0, 1)), 1'b0);
      check_read(n - 1);
      check_read(n);
      check_read($urandom_range(0, 255));
    end

    // Reset in the middle of DATA.
    stream = {8'd4, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    run_load(1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    ref_cnt = 0;
    @(negedge clk);
    resetn = 1'b1;
    check_reset_outputs("midload_reset");
    xf0 = xfers;
    pif.byte_in = 8'h77;
    pif.byte_valid = 1'b1;
    repeat (5) @(negedge clk);
    pif.byte_valid = 1'b0;
    chk("no_xfer_after_reset", 32'(xfers - xf0), 32'd0);
    chk("after_reset_cpu_run", 32'(cpu_run), 32'd0);

    stream = {8'd1};
    add_word(32'hCAFEF00D);
    finish_stream(8'd0);
    run_load(1'b0, 1'b0);
    check_read(0);
    check_read(1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
